// File: rtl/cpu_defs.sv
// Shared execute-stage definitions: bus widths, alu_op bit indices, divide FSM encoding.
package cpu_defs;

    localparam int DS_TO_ES_BUS_WD = 155;
    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int ES_FWD_BUS_WD   = 39;
    localparam int ALU_OP_WD       = 19;

    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_SLT   = 2;
    localparam int ALU_SLTU  = 3;
    localparam int ALU_AND   = 4;
    localparam int ALU_NOR   = 5;
    localparam int ALU_OR    = 6;
    localparam int ALU_XOR   = 7;
    localparam int ALU_SLL   = 8;
    localparam int ALU_SRL   = 9;
    localparam int ALU_SRA   = 10;
    localparam int ALU_LUI   = 11;
    localparam int ALU_MUL   = 12;
    localparam int ALU_MULH  = 13;
    localparam int ALU_MULHU = 14;
    localparam int ALU_DIV   = 15;
    localparam int ALU_DIVU  = 16;
    localparam int ALU_MOD   = 17;
    localparam int ALU_MODU  = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [ALU_OP_WD-1:0] alu_op;
        logic [31:0]          src1;
        logic [31:0]          src2;
        logic [4:0]           dest;
        logic                 gr_we;
        logic                 mem_we;
        logic                 res_from_mem;
        logic [31:0]          rkd_value;
        logic [31:0]          pc;
    } ds_to_es_t;

    typedef struct packed {
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_to_ms_t;

    function automatic logic is_div_op(input logic [ALU_OP_WD-1:0] op);
        return |op[ALU_MODU:ALU_DIV];
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational alu plus a 32-step restoring divider started by a one-cycle es_valid_i strobe.
module alu
    import cpu_defs::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ALU_OP_WD-1:0] alu_op_i,
    input  logic [31:0]          src1_i,
    input  logic [31:0]          src2_i,
    input  logic                 es_valid_i,
    output logic [31:0]          result_o,
    output logic                 div_finished_o
);
    logic        sgn;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        fin_q;

    assign sgn    = alu_op_i[ALU_DIV] | alu_op_i[ALU_MOD];
    assign a_abs  = (sgn & src1_i[31]) ? 32'd0 - src1_i : src1_i;
    assign b_abs  = (sgn & src2_i[31]) ? 32'd0 - src2_i : src2_i;
    assign prod_s = $signed({{32{src1_i[31]}}, src1_i}) * $signed({{32{src2_i[31]}}, src2_i});
    assign prod_u = {32'd0, src1_i} * {32'd0, src2_i};
    assign rem_sh = {rem_q, quo_q[31]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    // Operands stay stable in the payload register, so signs are fixed up live.
    assign quo_fix = (sgn & (src1_i[31] ^ src2_i[31])) ? 32'd0 - quo_q : quo_q;
    assign rem_fix = (sgn & src1_i[31]) ? 32'd0 - rem_q : rem_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            fin_q  <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            fin_q <= 1'b0;
            if (es_valid_i) begin
                busy_q <= 1'b1;
                cnt_q  <= '0;
                rem_q  <= '0;
                quo_q  <= a_abs;
                dvs_q  <= b_abs;
            end else if (busy_q) begin
                if (!diff[32]) begin
                    rem_q <= diff[31:0];
                    quo_q <= {quo_q[30:0], 1'b1};
                end else begin
                    rem_q <= rem_sh[31:0];
                    quo_q <= {quo_q[30:0], 1'b0};
                end
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    busy_q <= 1'b0;
                    fin_q  <= 1'b1;
                end
            end
        end
    end

    assign div_finished_o = fin_q;

    always_comb begin
        result_o = '0;
        unique case (1'b1)
            alu_op_i[ALU_ADD]:   result_o = src1_i + src2_i;
            alu_op_i[ALU_SUB]:   result_o = src1_i - src2_i;
            alu_op_i[ALU_SLT]:   result_o = {31'd0, $signed(src1_i) < $signed(src2_i)};
            alu_op_i[ALU_SLTU]:  result_o = {31'd0, src1_i < src2_i};
            alu_op_i[ALU_AND]:   result_o = src1_i & src2_i;
            alu_op_i[ALU_NOR]:   result_o = ~(src1_i | src2_i);
            alu_op_i[ALU_OR]:    result_o = src1_i | src2_i;
            alu_op_i[ALU_XOR]:   result_o = src1_i ^ src2_i;
            alu_op_i[ALU_SLL]:   result_o = src1_i << src2_i[4:0];
            alu_op_i[ALU_SRL]:   result_o = src1_i >> src2_i[4:0];
            alu_op_i[ALU_SRA]:   result_o = 32'($signed(src1_i) >>> src2_i[4:0]);
            alu_op_i[ALU_LUI]:   result_o = src2_i;
            alu_op_i[ALU_MUL]:   result_o = prod_u[31:0];
            alu_op_i[ALU_MULH]:  result_o = prod_s[63:32];
            alu_op_i[ALU_MULHU]: result_o = prod_u[63:32];
            alu_op_i[ALU_DIV]:   result_o = quo_fix;
            alu_op_i[ALU_DIVU]:  result_o = quo_fix;
            alu_op_i[ALU_MOD]:   result_o = rem_fix;
            alu_op_i[ALU_MODU]:  result_o = rem_fix;
            default:             result_o = '0;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: pipeline register, divide stall FSM, data-SRAM request, forwarding bus.
// Define EXE_FWD_EN to expose the live result on es_fwd_bus for bypass.
module exe_stage
    import cpu_defs::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_allowin,
    input  logic                       ms_allowin,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata,
    output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus
);
    ds_to_es_t  ds_q;
    ds_to_es_t  ds_d;
    logic       es_valid_q;
    logic       es_valid_d;
    div_state_e state_q;
    div_state_e state_d;
    logic [31:0] result_q;
    logic [31:0] result_d;

    logic        is_div;
    logic        div_done;
    logic        es_ready_go;
    logic        div_start;
    logic        div_finished;
    logic        handoff;
    logic        es_blocking;
    logic [31:0] alu_result;
    logic [31:0] es_result;
    es_to_ms_t   ms_bus;

    assign is_div         = is_div_op(ds_q.alu_op);
    assign div_done       = (state_q == DONE);
    assign es_ready_go    = ~is_div | div_done;
    assign es_allowin     = ~es_valid_q | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid_q & es_ready_go;
    assign handoff        = es_to_ms_valid & ms_allowin;

    assign es_valid_d = es_allowin ? ds_to_es_valid : es_valid_q;
    assign ds_d       = (ds_to_es_valid & es_allowin) ? ds_to_es_t'(ds_to_es_bus) : ds_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            ds_q       <= '0;
            state_q    <= IDLE;
            result_q   <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            ds_q       <= ds_d;
            state_q    <= state_d;
            result_q   <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        div_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (es_valid_q & is_div) begin
                    div_start = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (div_finished) begin
                    result_d = alu_result;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (handoff) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    alu u_alu (
        .clk_i          (clk),
        .rst_i          (reset),
        .alu_op_i       (ds_q.alu_op),
        .src1_i         (ds_q.src1),
        .src2_i         (ds_q.src2),
        .es_valid_i     (div_start),
        .result_o       (alu_result),
        .div_finished_o (div_finished)
    );

    // Once captured, the quotient/remainder must not follow the live divider.
    assign es_result = div_done ? result_q : alu_result;

    assign ms_bus.res_from_mem = ds_q.res_from_mem;
    assign ms_bus.gr_we        = ds_q.gr_we;
    assign ms_bus.dest         = ds_q.dest;
    assign ms_bus.result       = es_result;
    assign ms_bus.pc           = ds_q.pc;
    assign es_to_ms_bus        = ms_bus;

    assign data_sram_en    = handoff & (ds_q.mem_we | ds_q.res_from_mem);
    assign data_sram_we    = {4{ds_q.mem_we & data_sram_en}};
    assign data_sram_addr  = es_result;
    assign data_sram_wdata = ds_q.rkd_value;

`ifdef EXE_FWD_EN
    assign es_blocking = es_valid_q & (ds_q.res_from_mem | (is_div & ~div_done));
    assign es_fwd_bus  = {es_valid_q & ds_q.gr_we, es_blocking, ds_q.dest, es_result};
`else
    assign es_blocking = es_valid_q & ds_q.gr_we;
    assign es_fwd_bus  = {es_valid_q & ds_q.gr_we, es_blocking, ds_q.dest, 32'd0};
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed vectors, queued expectations, decoupled monitor.
module tb_exe_stage;
    import cpu_defs::*;

    logic         clk;
    logic         reset;
    logic         ds_to_es_valid;
    logic [154:0] ds_to_es_bus;
    logic         es_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [38:0]  es_fwd_bus;

    int n_checks = 0;
    int n_fail = 0;
    int strobes = 0;
    int exp_strobes = 0;

    logic [70:0] exp_q[$];
    logic [67:0] sram_q[$];

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_allowin      (es_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .es_fwd_bus      (es_fwd_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [154:0] mk(input int op, input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [4:0] d, input logic gw, input logic mw,
                                        input logic rfm, input logic [31:0] rkd, input logic [31:0] pc);
        logic [18:0] oh;
        oh = 19'd1 << op;
        return {oh, s1, s2, d, gw, mw, rfm, rkd, pc};
    endfunction

    task automatic send(input int op, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [4:0] d, input logic gw, input logic mw, input logic rfm,
                        input logic [31:0] rkd, input logic [31:0] pc, input logic [31:0] res);
        int n;
        exp_q.push_back({rfm, gw, d, res, pc});
        if (mw | rfm) sram_q.push_back({{4{mw}}, res, rkd});
        if (op >= ALU_DIV) exp_strobes++;
        @(negedge clk);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(op, s1, s2, d, gw, mw, rfm, rkd, pc);
        #1;
        n = 0;
        while (!es_allowin && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: allowin stuck at %b, required 1", es_allowin);
        end
        @(posedge clk);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
    endtask

    // Monitor: sample mid-low-phase, after inputs settle and before the next edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (dut.u_alu.es_valid_i) strobes++;
            if (es_to_ms_valid && ms_allowin) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL es_to_ms_extra: got %h, required no handoff", es_to_ms_bus);
                end else begin
                    check("es_to_ms_bus", es_to_ms_bus, exp_q.pop_front());
                end
            end
            if (data_sram_en) begin
                check("sram_on_handoff", {70'd0, es_to_ms_valid & ms_allowin}, 71'd1);
                if (sram_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sram_extra: got addr %h, required no request", data_sram_addr);
                end else begin
                    check("sram_req", {3'd0, data_sram_we, data_sram_addr, data_sram_wdata},
                          {3'd0, sram_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int n;
        int bad;
        reset          = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        ms_allowin     = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_allowin", {70'd0, es_allowin}, 71'd1);
        check("rst_valid", {70'd0, es_to_ms_valid}, 71'd0);
        check("rst_sram_en", {70'd0, data_sram_en}, 71'd0);
        check("rst_sram_we", {67'd0, data_sram_we}, 71'd0);
        @(negedge clk);
        reset = 1'b0;

        send(ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 32'h100, 32'd12);
        #1;
        check("add_next_cycle_valid", {70'd0, es_to_ms_valid}, 71'd1);
        check("add_no_sram", {70'd0, data_sram_en}, 71'd0);
        send(ALU_SUB, 32'd20, 32'd5, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0, 32'h104, 32'd15);
        send(ALU_XOR, 32'hF0F0, 32'h0FF0, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0, 32'h108, 32'hFF00);
        send(ALU_SLT, 32'hFFFFFFFD, 32'd2, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0, 32'h10C, 32'd1);

        send(ALU_DIV, 32'd100, 32'd7, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0, 32'h110, 32'd14);
        #1;
        check("div_stalls_allowin", {70'd0, es_allowin}, 71'd0);
        check("div_busy_blocking", {70'd0, es_fwd_bus[37]}, 71'd1);
        send(ALU_MOD, 32'd100, 32'd7, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0, 32'h114, 32'd2);
        send(ALU_DIV, 32'hFFFFFF9C, 32'd7, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0, 32'h118, 32'hFFFFFFF2);
        send(ALU_MOD, 32'hFFFFFF9C, 32'd7, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0, 32'h11C, 32'hFFFFFFFE);

        send(ALU_DIV, 32'd100, 32'd7, 5'd8, 1'b1, 1'b0, 1'b0, 32'd0, 32'h120, 32'd14);
        ms_allowin = 1'b0;
        #1;
        n = 0;
        while (!es_to_ms_valid && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("bp_div_completes", {70'd0, es_to_ms_valid}, 71'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("bp_hold_result", {39'd0, es_to_ms_bus[63:32]}, 71'd14);
        end
        @(negedge clk);
        ms_allowin = 1'b1;

        send(ALU_DIVU, 32'd200, 32'd10, 5'd11, 1'b1, 1'b0, 1'b0, 32'd0, 32'h124, 32'd20);
        send(ALU_MODU, 32'd45, 32'd6, 5'd12, 1'b1, 1'b0, 1'b0, 32'd0, 32'h128, 32'd3);

        send(ALU_ADD, 32'h1000, 32'd4, 5'd0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h130, 32'h1004);
        ms_allowin = 1'b0;
        #1;
        check("st_stall_no_req", {70'd0, data_sram_en}, 71'd0);
        @(negedge clk);
        #1;
        check("st_stall_no_req2", {70'd0, data_sram_en}, 71'd0);
        @(negedge clk);
        ms_allowin = 1'b1;

        send(ALU_DIV, 32'd100, 32'd7, 5'd13, 1'b1, 1'b0, 1'b0, 32'd0, 32'h134, 32'd14);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_busy_allowin", {70'd0, es_allowin}, 71'd1);
        check("rst_busy_valid", {70'd0, es_to_ms_valid}, 71'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (es_to_ms_valid || !es_allowin) bad++;
        end
        check("post_rst_quiet", 71'(bad), 71'd0);

        ms_allowin = 1'b0;
        send(ALU_ADD, 32'h2000, 32'd8, 5'd9, 1'b1, 1'b0, 1'b1, 32'd0, 32'h140, 32'h2008);
        #1;
        check("ld_fwd_hdr", {64'd0, es_fwd_bus[38:32]}, {64'd0, 2'b11, 5'd9});
`ifdef EXE_FWD_EN
        check("ld_fwd_res", {39'd0, es_fwd_bus[31:0]}, 71'h2008);
`else
        check("ld_fwd_res", {39'd0, es_fwd_bus[31:0]}, 71'd0);
`endif
        @(negedge clk);
        ms_allowin = 1'b1;
        @(negedge clk);
        ms_allowin = 1'b0;
        send(ALU_ADD, 32'd3, 32'd4, 5'd10, 1'b1, 1'b0, 1'b0, 32'd0, 32'h144, 32'd7);
        #1;
`ifdef EXE_FWD_EN
        check("add_fwd", {32'd0, es_fwd_bus}, {32'd0, 2'b10, 5'd10, 32'd7});
`else
        check("add_fwd", {32'd0, es_fwd_bus}, {32'd0, 2'b11, 5'd10, 32'd0});
`endif
        @(negedge clk);
        ms_allowin = 1'b1;

        n = 0;
        while ((exp_q.size() != 0 || sram_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #3;
        check("drain_es_to_ms", 71'(exp_q.size()), 71'd0);
        check("drain_sram", 71'(sram_q.size()), 71'd0);
        check("div_start_strobes", 71'(strobes), 71'(exp_strobes));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
